bnn_host_driver: RTL

BNN_HOST_DRIVER -- requirements
Module: bnn_host_driver

---
 rtl/bnn_host_driver.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bnn_host_driver.sv
// rtl/bnn_host_driver.sv - host-side frame streamer and result capture for the BNN accelerator
// Optional watchdog on the result wait: define BNN_HOST_TIMEOUT_EN.
module bnn_host_driver (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        start_mode,
    input  logic [7:0]  start_len,
    input  logic        src_valid,
    input  logic [15:0] src_data,
    output logic        src_ready,
    output logic        acc_mode,
    output logic        acc_valid,
    output logic [15:0] acc_data,
    input  logic        acc_ready,
    input  logic        acc_out_en,
    input  logic [1:0]  acc_data_out,
    output logic        busy,
    output logic        done,
    output logic        result_valid,
    output logic [3:0]  result,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, RES_LO} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  remaining;
    logic        src_fire;
    logic        last_drain;
    logic        done_set;
    logic        res_set;
    logic        load_cmd;
    logic [15:0] data_mapped;

    assign src_ready  = (state == STREAM) && (remaining != 8'd0) && (!acc_valid || acc_ready);
    assign src_fire   = src_valid && src_ready;
    assign last_drain = (state == STREAM) && (remaining == 8'd0) && (!acc_valid || acc_ready);
    assign load_cmd   = (state == IDLE) && start && (start_len != 8'd0);
    assign busy       = (state != IDLE);

    // Weight words are presented MSB-first to the accelerator.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            data_mapped[i] = acc_mode ? src_data[15 - i] : src_data[i];
        end
    end

`ifdef BNN_HOST_TIMEOUT_EN
    logic [11:0] wd_cnt;
    logic        to_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= 12'd0;
        end else if (state != WAIT_RES) begin
            wd_cnt <= 12'd0;
        end else begin
            wd_cnt <= wd_cnt + 12'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= to_set;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        done_set   = 1'b0;
        res_set    = 1'b0;
`ifdef BNN_HOST_TIMEOUT_EN
        to_set     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_len != 8'd0) begin
                        state_next = STREAM;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (last_drain) begin
                    if (acc_mode) begin
                        state_next = IDLE;
                        done_set   = 1'b1;
                    end else begin
                        state_next = WAIT_RES;
                    end
                end
            end
            WAIT_RES: begin
                if (acc_out_en) begin
                    state_next = RES_LO;
                end
`ifdef BNN_HOST_TIMEOUT_EN
                else if (wd_cnt == 12'hFFF) begin
                    state_next = IDLE;
                    done_set   = 1'b1;
                    to_set     = 1'b1;
                end
`endif
            end
            RES_LO: begin
                state_next = IDLE;
                done_set   = 1'b1;
                res_set    = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining    <= 8'd0;
            acc_mode     <= 1'b0;
            acc_valid    <= 1'b0;
            acc_data     <= 16'd0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            result       <= 4'd0;
        end else begin
            done         <= done_set;
            result_valid <= res_set;

            if (load_cmd) begin
                remaining <= start_len;
                acc_mode  <= start_mode;
            end else if (src_fire) begin
                remaining <= remaining - 8'd1;
            end

            if (src_fire) begin
                acc_valid <= 1'b1;
                acc_data  <= data_mapped;
            end else if (acc_ready) begin
                acc_valid <= 1'b0;
            end

            if (state == WAIT_RES && acc_out_en) begin
                result[3:2] <= acc_data_out;
            end
`ifdef BNN_HOST_TIMEOUT_EN
            else if (to_set) begin
                result <= 4'hF;
            end
`endif
            if (state == RES_LO) begin
                result[1:0] <= acc_data_out;
            end
        end
    end

endmodule
